msg_receiver: RTL and testbench
===============================

MSG_RECEIVER -- requirements
Module: msg_receiver

Interface
REQ-001 The module SHALL have: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 The module SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 The module SHALL have: serIn  input  1  serial line, idle high; frame = start(0), 8 data LSB-first, optional parity, stop(1).
REQ-004 The module SHALL have: div  input  10  clk cycles per bit; values 0 and 1 are treated as 2.
REQ-005 The module SHALL have: parEn  input  1  1 = one even-parity bit follows the data bits.
REQ-006 The module SHALL have: dataOut  output  8  last correctly received byte; holds its value between frames.
REQ-007 The module SHALL have: valid  output  1  one-cycle pulse when dataOut is updated.
REQ-008 The module SHALL have: frameErr  output  1  one-cycle pulse when the stop bit is sampled 0.
REQ-009 The module SHALL have: parErr  output  1  one-cycle pulse when the parity check fails.
REQ-010 The module SHALL have: busy  output  1  high in every state except IDLE.

Function
REQ-011 serIn SHALL pass through a 2-flop synchronizer (reset value 1); "line" below means the synchronizer output.
REQ-012 div and parEn SHALL be latched on leaving IDLE and held constant for the whole frame.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START SHALL occur on a line falling edge (previous line 1, current line 0); the bit counter loads floor(D/2)-1, where D is the effective div.
REQ-015 A down-counter SHALL decrement every cycle; the sample point is the cycle in which the counter equals 0, and the counter reloads D-1 at every sample point.
REQ-016 START sample: line 0 -> DATA with bit index 0; line 1 -> IDLE with no output pulse (false start).
REQ-017 DATA SHALL shift the sampled bit into shift[bit index], LSB first; after the 8th sample it SHALL go to PARITY if parEn = 1, else to STOP.
REQ-018 PARITY SHALL sample one bit; the XOR of the 8 data bits and the parity bit SHALL equal 0, else a parity-fail flag is set; the state then goes to STOP.
REQ-019 STOP sample, line 1, no parity fail: dataOut <= shift and valid = 1.
REQ-020 STOP sample, line 1, parity fail: parErr = 1 and dataOut is unchanged.
REQ-021 STOP sample, line 0: frameErr = 1 (parErr is not asserted) and dataOut is unchanged.
REQ-022 After any STOP outcome, the FSM SHALL return to IDLE on the same edge.
REQ-023 At most one of valid, frameErr and parErr SHALL be high in any cycle; each pulse is exactly one clk cycle wide.
REQ-024 Output pulses SHALL be registered and high in the cycle following the STOP sample edge.
REQ-025 A new frame's falling edge SHALL be recognised no earlier than the first IDLE cycle; back-to-back frames with a one-bit stop SHALL be received without loss.
REQ-026 A line held low in IDLE (break condition) SHALL NOT retrigger; a new frame requires line 1 followed by line 0.
REQ-027 Latency: valid SHALL rise (2 sync + floor(D/2) + (9 or 10)*D + 1) cycles, ±1, after serIn first goes low.

Reset
REQ-028 rst = 1 SHALL immediately force: state IDLE, counters 0, shift 0, synchronizer flops 1.
REQ-029 rst = 1 SHALL immediately force outputs: dataOut 8'h00, valid 0, frameErr 0, parErr 0, busy 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-031 After reset is released, the next falling edge starts a fresh frame.

Verification
REQ-032 Basic receive: div = 10, parEn = 0, frame for 8'hA5 -> single valid pulse, dataOut = 8'hA5, no error pulses, busy low after the frame.
REQ-033 Parity receive: div = 16, parEn = 1, byte 8'h3C with parity 0 -> valid, dataOut = 8'h3C; same byte with parity 1 -> parErr pulse, dataOut stays 8'h3C from the prior frame.
REQ-034 Framing error: div = 10, byte 8'hFF with stop bit driven 0 -> frameErr pulse, no valid, dataOut unchanged.
REQ-035 False start: div = 20, serIn low for 4 cycles then high -> busy returns low after the START sample, with no pulses.
REQ-036 Back-to-back: div = 8, bytes 8'h01, 8'h80, 8'h55 sent contiguously -> three valid pulses, with dataOut in that order.
REQ-037 Mid-frame reset and divisor clamp: rst pulsed during DATA -> outputs return to reset values and the next frame 8'h5A is received correctly; div = 0 is received as if div = 2.

Source files
------------

// File: rtl/msg_receiver.sv
// rtl/msg_receiver.sv - asynchronous serial byte receiver with optional even parity
// Oversamples the synchronized line with a programmable divisor and samples mid-bit.
module msg_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       serIn,
  input  logic [9:0] div,
  input  logic       parEn,
  output logic [7:0] dataOut,
  output logic       valid,
  output logic       frameErr,
  output logic       parErr,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_nx;
  logic       sync1, line, line_q;
  logic [9:0] cnt, d_lat, d_eff;
  logic       par_lat, perr;
  logic [2:0] idx;
  logic [7:0] shift;
  logic       fall, sample;
  logic       valid_nx, ferr_nx, perr_nx;

  // Divisors below 2 cannot place a mid-bit sample, so they are clamped.
  assign d_eff  = (div < 10'd2) ? 10'd2 : div;
  assign fall   = line_q & ~line;
  assign sample = (cnt == 10'd0);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (fall) state_nx = START;
      START:  if (sample) state_nx = line ? IDLE : DATA;
      DATA:   if (sample && idx == 3'd7) state_nx = par_lat ? PARITY : STOP;
      PARITY: if (sample) state_nx = STOP;
      STOP:   if (sample) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    perr_nx  = 1'b0;
    if (state == STOP && sample) begin
      if (!line)     ferr_nx  = 1'b1;
      else if (perr) perr_nx  = 1'b1;
      else           valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      line     <= 1'b1;
      line_q   <= 1'b1;
      cnt      <= 10'd0;
      d_lat    <= 10'd0;
      par_lat  <= 1'b0;
      perr     <= 1'b0;
      idx      <= 3'd0;
      shift    <= 8'h00;
      dataOut  <= 8'h00;
      valid    <= 1'b0;
      frameErr <= 1'b0;
      parErr   <= 1'b0;
    end else begin
      sync1    <= serIn;
      line     <= sync1;
      line_q   <= line;
      valid    <= valid_nx;
      frameErr <= ferr_nx;
      parErr   <= perr_nx;
      if (state == IDLE) begin
        if (fall) begin
          cnt     <= (d_eff >> 1) - 10'd1;
          d_lat   <= d_eff;
          par_lat <= parEn;
          idx     <= 3'd0;
          perr    <= 1'b0;
        end else begin
          cnt <= 10'd0;
        end
      end else if (sample) begin
        cnt <= d_lat - 10'd1;
      end else begin
        cnt <= cnt - 10'd1;
      end
      if (state == DATA && sample) begin
        shift[idx] <= line;
        idx        <= idx + 3'd1;
      end
      if (state == PARITY && sample) perr <= ^{shift, line};
      if (valid_nx) dataOut <= shift;
    end
  end

endmodule

// File: tb/tb_msg_receiver.sv
// tb/tb_msg_receiver.sv - directed self-checking bench for msg_receiver
module tb_msg_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serIn = 1'b1;
  logic [9:0] div = 10'd10;
  logic       parEn = 1'b0;
  logic [7:0] dataOut;
  logic       valid, frameErr, parErr, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt = 0, fecnt = 0, pecnt = 0, overlap = 0, wide = 0;
  int vtime = 0, t_start = 0;
  logic [7:0] vlog [0:63];
  logic prev_pulse = 1'b0;
  int v0, f0, p0;

  msg_receiver dut (
    .clk(clk), .rst(rst), .serIn(serIn), .div(div), .parEn(parEn),
    .dataOut(dataOut), .valid(valid), .frameErr(frameErr), .parErr(parErr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      vlog[vcnt[5:0]] = dataOut;
      vcnt++;
      vtime = cyc;
    end
    if (frameErr) fecnt++;
    if (parErr) pecnt++;
    if ((int'(valid) + int'(frameErr) + int'(parErr)) > 1) overlap++;
    if (prev_pulse && (valid | frameErr | parErr)) wide++;
    prev_pulse = valid | frameErr | parErr;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int d);
    serIn = v;
    repeat (d) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic use_par, input logic pbit,
                            input logic stopv, input logic idle_v, input int d);
    t_start = cyc;
    send_bit(1'b0, d);
    for (int i = 0; i < 8; i++) send_bit(b[i], d);
    if (use_par) send_bit(pbit, d);
    send_bit(stopv, d);
    serIn = idle_v;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(n < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic snap();
    v0 = vcnt; f0 = fecnt; p0 = pecnt;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", dataOut, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frameErr, 0);
    chk("rst_perr", parErr, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic receive with latency check
    div = 10'd10; parEn = 1'b0; snap();
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    wait_idle("a5_to");
    chk("a5_valid", vcnt - v0, 1);
    chk("a5_data", dataOut, 8'hA5);
    chk("a5_ferr", fecnt - f0, 0);
    chk("a5_perr", pecnt - p0, 0);
    chk("a5_busy", busy, 0);
    chk("a5_lat", int'((vtime - t_start) >= 97 && (vtime - t_start) <= 99), 1);

    // Parity good then bad
    div = 10'd16; parEn = 1'b1; snap();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16);
    wait_idle("p_ok_to");
    chk("p_ok_valid", vcnt - v0, 1);
    chk("p_ok_data", dataOut, 8'h3C);
    chk("p_ok_perr", pecnt - p0, 0);
    snap();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 16);
    wait_idle("p_bad_to");
    chk("p_bad_perr", pecnt - p0, 1);
    chk("p_bad_valid", vcnt - v0, 0);
    chk("p_bad_data", dataOut, 8'h3C);

    // Framing error followed by a held-low break
    div = 10'd10; parEn = 1'b0; snap();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    repeat (30) @(negedge clk);
    chk("brk_busy", busy, 0);
    chk("fe_ferr", fecnt - f0, 1);
    chk("fe_valid", vcnt - v0, 0);
    chk("fe_perr", pecnt - p0, 0);
    chk("fe_data", dataOut, 8'h3C);
    serIn = 1'b1;
    repeat (5) @(negedge clk);

    // False start
    div = 10'd20; snap();
    send_bit(1'b0, 4);
    serIn = 1'b1;
    @(negedge clk);
    chk("fs_busy_hi", busy, 1);
    repeat (20) @(negedge clk);
    chk("fs_busy_lo", busy, 0);
    chk("fs_pulses", (vcnt - v0) + (fecnt - f0) + (pecnt - p0), 0);

    // Back-to-back
    div = 10'd8; snap();
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 8);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8);
    wait_idle("b2b_to");
    chk("b2b_count", vcnt - v0, 3);
    chk("b2b_0", vlog[v0[5:0]], 8'h01);
    chk("b2b_1", vlog[6'(v0 + 1)], 8'h80);
    chk("b2b_2", vlog[6'(v0 + 2)], 8'h55);
    chk("b2b_err", (fecnt - f0) + (pecnt - p0), 0);

    // Mid-frame reset
    div = 10'd10; snap();
    send_bit(1'b0, 10);
    send_bit(1'b1, 30);
    chk("mr_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_data", dataOut, 8'h00);
    chk("mr_pulse", int'(valid | frameErr | parErr), 0);
    @(negedge clk);
    serIn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mr_nopulse", (vcnt - v0) + (fecnt - f0) + (pecnt - p0), 0);
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 10);
    wait_idle("mr_to");
    chk("mr_valid", vcnt - v0, 1);
    chk("mr_5a", dataOut, 8'h5A);

    // Divisor 0 behaves as 2
    div = 10'd0; snap();
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    repeat (6) @(negedge clk);
    wait_idle("d0_to");
    chk("d0_valid", vcnt - v0, 1);
    chk("d0_data", dataOut, 8'hC3);

    chk("overlap", overlap, 0);
    chk("width", wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
